// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - shift-add 32x32->64 multiply sequencer driving a shared ALU
//
// Runs MULT/MULTU as a shift-add multiply on an external 32-bit combinational ALU.
// The ALU supplies add, sub and unsigned less-than. The signed correction is applied
// to the high word at the end of the operation.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, sign_op    request (sampled when idle), 1 = signed MULT
//   rs, rt            multiplicand, multiplier
//   busy, done        operation in flight, one-cycle completion pulse
//   hi, lo            product [63:32], [31:0]; held until the next done
//   alu_a, alu_b      ALU operands
//   alu_fun, alu_sign ALU function select; sign is always 0 (unsigned compare)
//   alu_z             ALU result, consumed in the same cycle
module mult_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_z
);

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_LT  = 6'b110101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ITER  = 3'd1,
    CARRY = 3'd2,
    FIX_A = 3'd3,
    FIX_B = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [31:0] mcand;
  logic [31:0] rt_orig;   // pl is shifted away, so the sign fix needs its own copy
  logic [31:0] ph;
  logic [31:0] pl;
  logic [31:0] sum;
  logic [4:0]  cnt;
  logic        sgn;

  wire fix_a_sub = sgn && mcand[31];
  wire fix_b_sub = sgn && rt_orig[31];

  assign busy     = (state != IDLE);
  assign alu_sign = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    alu_a   = 32'h0;
    alu_b   = 32'h0;
    alu_fun = FUN_ADD;
    case (state)
      IDLE: begin
        if (start) state_n = ITER;
      end
      ITER: begin
        if (pl[0]) begin
          alu_a   = ph;
          alu_b   = mcand;
          state_n = CARRY;
        end else if (cnt == 5'd31) begin
          state_n = FIX_A;
        end
      end
      CARRY: begin
        // sum = ph + mcand (mod 2^32) wrapped iff sum < mcand
        alu_a   = sum;
        alu_b   = mcand;
        alu_fun = FUN_LT;
        state_n = (cnt == 5'd31) ? FIX_A : ITER;
      end
      FIX_A: begin
        if (fix_a_sub) begin
          alu_a   = ph;
          alu_b   = rt_orig;
          alu_fun = FUN_SUB;
        end
        state_n = FIX_B;
      end
      FIX_B: begin
        if (fix_b_sub) begin
          alu_a   = ph;
          alu_b   = mcand;
          alu_fun = FUN_SUB;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= 32'h0;
      rt_orig <= 32'h0;
      ph      <= 32'h0;
      pl      <= 32'h0;
      sum     <= 32'h0;
      cnt     <= 5'd0;
      sgn     <= 1'b0;
      hi      <= 32'h0;
      lo      <= 32'h0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand   <= rs;
            rt_orig <= rt;
            pl      <= rt;
            ph      <= 32'h0;
            cnt     <= 5'd0;
            sgn     <= sign_op;
          end
        end
        ITER: begin
          if (pl[0]) begin
            sum <= alu_z;
          end else begin
            {ph, pl} <= {1'b0, ph, pl[31:1]};
            cnt      <= cnt + 5'd1;
          end
        end
        CARRY: begin
          {ph, pl} <= {alu_z[0], sum, pl[31:1]};
          cnt      <= cnt + 5'd1;
        end
        FIX_A: begin
          if (fix_a_sub) ph <= alu_z;
        end
        FIX_B: begin
          hi   <= fix_b_sub ? alu_z : ph;
          lo   <= pl;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - self-checking bench for mult_sequencer with an ALU model
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_z;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit checking  = 1'b0;

  always #5 clk = ~clk;

  // Shared ALU: add, sub, unsigned less-than
  assign alu_z = (alu_fun == 6'b000000) ? alu_a + alu_b :
                 (alu_fun == 6'b000001) ? alu_a - alu_b :
                 (alu_fun == 6'b110101) ? {31'b0, alu_a < alu_b} : 32'h0;

  mult_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .sign_op(sign_op),
    .rs(rs), .rt(rt), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_z(alu_z)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] product(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Behavioural model: an accepted start makes busy last 34+popcount(rt) cycles,
  // then done pulses with the product in hi/lo.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic [63:0] m_res = 64'h0;
  int          m_rem = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = 32'h0; m_lo = 32'h0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = m_res[63:32];
          m_lo   = m_res[31:0];
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_res  = product(sign_op, rs, rt);
        m_rem  = 34 + $countones(rt);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy", {63'b0, busy}, {63'b0, m_busy});
      check("done", {63'b0, done}, {63'b0, m_done});
      check("hi", {32'b0, hi}, {32'b0, m_hi});
      check("lo", {32'b0, lo}, {32'b0, m_lo});
      check("alu_sign", {63'b0, alu_sign}, 64'h0);
      if (!m_busy) begin
        check("idle_alu_fun", {58'b0, alu_fun}, 64'h0);
        check("idle_alu_ab", {alu_a, alu_b}, 64'h0);
      end
    end
  end

  // Called at #1 after a posedge; start is raised immediately so a call
  // made in a done cycle issues a back-to-back operation.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input bit mid);
    int n;
    sign_op = s; rs = a; rt = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (mid && n == 10) begin
        start = 1'b1; sign_op = ~s; rs = ~a; rt = b ^ 32'h0000_1234;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check("done_seen", {63'b0, done}, 64'h1);
    check("latency", 64'(n), 64'(exp_lat));
    check("result", {hi, lo}, {exp_hi, exp_lo});
    check("busy_at_done", {63'b0, busy}, 64'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    logic [63:0] p;
    int          dones;
    reset = 1'b1; start = 1'b0; sign_op = 1'b0; rs = 32'h0; rt = 32'h0;
    @(posedge clk); #1;
    checking = 1'b1;
    @(posedge clk); #1;
    check("reset_busy", {63'b0, busy}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Hand-computed cases
    run_op(1'b0, 32'd3, 32'd5, 32'h0, 32'hF, 37, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 67, 1'b0);
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 67, 1'b0);
    run_op(1'b1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 37, 1'b0);
    run_op(1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0, 35, 1'b0);
    // Start mid-operation is ignored
    run_op(1'b0, 32'd7, 32'd9, 32'h0, 32'd63, 37, 1'b1);
    // Back-to-back: start issued in the done cycle
    run_op(1'b1, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 35 + 30, 1'b0);

    // Reset during CARRY: rt bit0 = 1 puts cycle 2 in CARRY
    repeat (2) @(posedge clk); #1;
    sign_op = 1'b0; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("carry_state_fun", {58'b0, alu_fun}, 64'h35);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'h0);
    check("abort_done", {63'b0, done}, 64'h0);
    check("abort_hilo", {hi, lo}, 64'h0);
    check("abort_fun", {58'b0, alu_fun}, 64'h0);
    dones = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'h0);
    run_op(1'b0, 32'd100, 32'd200, 32'h0, 32'd20000, 38, 1'b0);

    // Randomized operations with occasional back-to-back issue
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = b & 32'h8000_00FF;
      p = product(s, a, b);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      run_op(s, a, b, p[63:32], p[31:0], 35 + $countones(b), (i % 7) == 3);
    end

    repeat (3) @(posedge clk);
    #1;
    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle 32x32->64 multiply controller for the CPU's MULT/MULTU path. It owns no adder of its own. It sequences the shared 32-bit combinational ALU, using add, sub and unsigned less-than, to run a shift-add multiply, then applies a signed correction to the high word. Results go to the HI/LO registers.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sign_op  input  1  1 = MULT (signed), 0 = MULTU.
- rs  input  32  multiplicand.
- rt  input  32  multiplier.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle on.
- hi  output  32  product bits [63:32].
- lo  output  32  product bits [31:0].
- alu_a  output  32  to ALU operand A.
- alu_b  output  32  to ALU operand B.
- alu_fun  output  6  to ALU function select.
- alu_sign  output  1  to ALU Sign; always 0.
- alu_z  input  32  ALU result, combinational, used the same cycle.

## Operation
- ALU codes driven: ADD 6'b000000, SUB 6'b000001, LT 6'b110101 (alu_sign=0, unsigned).
- Internal registers:
  - mcand: latched rs.
  - ph: running high word.
  - pl: holds rt at the start, becomes lo.
  - sum: latched ALU sum.
  - cnt: 5-bit bit counter.
  - sgn: latched sign_op.
- States: IDLE, ITER, CARRY, FIX_A, FIX_B.
- IDLE
  - ALU outputs are 0, alu_fun=ADD.
  - On start: mcand<=rs, pl<=rt, ph<=0, cnt<=0, sgn<=sign_op; go to ITER.
- ITER
  - If pl[0]=0: shift {ph,pl} <= {1'b0, ph, pl[31:1]}, cnt++; no ALU use (alu_fun=ADD, operands 0).
  - If pl[0]=1: drive alu_a=ph, alu_b=mcand, ADD; sum<=alu_z; go to CARRY.
  - After the shift with cnt=31, go to FIX_A.
- CARRY
  - Drive alu_a=sum, alu_b=mcand, LT.
  - carry = alu_z[0].
  - Shift {ph,pl} <= {carry, sum, pl[31:1]}, cnt++.
  - Return to ITER, or go to FIX_A if cnt was 31.
- FIX_A
  - If sgn and mcand[31]: alu_a=ph, alu_b=original rt, SUB; ph<=alu_z.
  - Otherwise no change.
  - Go to FIX_B.
  - The original rt must be kept in a separate latched register, because pl is shifted.
- FIX_B
  - If sgn and rt[31]: alu_a=ph, alu_b=mcand, SUB; ph<=alu_z.
  - At the clock edge: hi<=ph (including this update), lo<=pl, done<=1; return to IDLE.
- Arithmetic is modulo 2^32 per word. Signed result = unsigned product minus sign corrections in the high word.
- start while busy=1: ignored. No queuing, and in-flight operands are not disturbed.
- hi/lo hold their last result until the next done. They are not cleared by start.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, alu_a=0, alu_b=0, alu_fun=6'b000000, alu_sign=0.
- Reset in any state aborts the operation next edge: all outputs return to reset values and no done is issued.
- Latency: start sampled at edge 0 gives done high in cycle 35+k, where k = popcount(rt).
  - One cycle per 0 bit and two per 1 bit: 32+k cycles.
  - Plus FIX_A, FIX_B, and the load cycle.
- Range: 35 cycles (rt=0) to 67 cycles (rt=0xFFFFFFFF).
- busy is high cycles 1..34+k and low in the done cycle.
- A start in the done cycle is accepted; back-to-back operations are allowed.
- done is exactly one cycle wide.
- ALU outputs are registered state decodes. alu_z is sampled in the same cycle, so the path is combinational through the ALU.

## Test plan
- MULTU rs=3, rt=5 -> done at cycle 37; hi=0x00000000, lo=0x0000000F; busy low at done.
- MULTU rs=rt=0xFFFFFFFF -> done at cycle 67; hi=0xFFFFFFFE, lo=0x00000001; checks carry from the CARRY state on every iteration.
- MULT rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001; both FIX subtractions occur.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; only FIX_A subtracts. MULT with rt=0 -> 0/0 after 35 cycles.
- Second start with new operands asserted mid-operation -> ignored; result matches the first operands. A start in the done cycle -> accepted; next result correct.
- Reset asserted during CARRY -> next cycle busy=0, done=0, hi=lo=0, alu_fun=0; no done pulse follows; a new start then completes normally.
